// File: rtl/pipelined_logic_unit.sv
// pipelined_logic_unit: STAGES-deep pipelined bitwise logic unit with valid/ready flow control and zero/ones flags
module pipelined_logic_unit #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_zero,
  output logic             result_ones
);
  logic [WIDTH-1:0] f;
  logic [STAGES-1:0] valid, zero, ones, ready;
  logic [WIDTH-1:0] data [STAGES];
  if (STAGES < 1 || WIDTH < 1) begin : g_bad_params
    $fatal(1, "pipelined_logic_unit: STAGES and WIDTH must be at least 1");
  end
  // bitwise operation selected by in_op
  always_comb begin
    case (in_op)
      3'd0: f = ~in_A;
      3'd1: f = in_A & in_B;
      3'd2: f = in_A | in_B;
      3'd3: f = in_A ^ in_B;
      3'd4: f = ~(in_A & in_B);
      3'd5: f = ~(in_A | in_B);
      3'd6: f = ~(in_A ^ in_B);
      default: f = in_A;
    endcase
  end
  // a stage may load unless it and every stage after it are full while the output stalls
  always_comb begin
    ready = '0;
    for (int s = 0; s < STAGES; s++) ready[s] = out_ready | ~&(valid | STAGES'((1 << s) - 1));
  end
  // stage 0 captures the computed beat; later stages move forward whenever they can load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
      zero <= '0;
      ones <= '0;
      for (int s = 0; s < STAGES; s++) data[s] <= '0;
    end else begin
      if (ready[0]) begin
        valid[0] <= in_valid;
        data[0] <= f;
        zero[0] <= f == '0;
        ones[0] <= &f;
      end
      for (int s = 1; s < STAGES; s++) begin
        if (ready[s]) begin
          valid[s] <= valid[s-1];
          data[s] <= data[s-1];
          zero[s] <= zero[s-1];
          ones[s] <= ones[s-1];
        end
      end
    end
  end
  assign in_ready = ready[0];
  assign out_valid = valid[STAGES-1];
  assign result = data[STAGES-1];
  assign result_zero = zero[STAGES-1];
  assign result_ones = ones[STAGES-1];
endmodule

// File: tb/tb_pipelined_logic_unit.sv
// tb_pipelined_logic_unit: random and directed stimulus on three configurations checked against a timing/queue model
module tb_pipelined_logic_unit;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0;
  logic out_ready = 0;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic [2:0] op = '0;
  int checks = 0;
  int failures = 0;
  always #10 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ref_op(logic [63:0] x, logic [63:0] y, logic [2:0] o);
    logic [63:0] r [8];
    r = '{~x, x & y, x | y, x ^ y, ~(x & y), ~(x | y), ~(x ^ y), x};
    return r[o];
  endfunction
  typedef struct {
    logic [63:0] d;
    int acc;
  } beat_t;
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int W = g == 0 ? 32 : 8;
    localparam int S = g == 0 ? 2 : g == 1 ? 1 : 4;
    localparam logic [63:0] M = (64'd1 << W) - 64'd1;
    logic ir, ov, rz, ro;
    logic [W-1:0] res;
    beat_t q[$];
    int cyc = 0;
    int last_dep = 0;
    bit acc_now = 0;
    bit emit_now = 0;
    pipelined_logic_unit #(.WIDTH(W), .STAGES(S)) dut (
      .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(ir),
      .in_A(a[W-1:0]), .in_B(b[W-1:0]), .in_op(op),
      .out_valid(ov), .out_ready(out_ready), .result(res),
      .result_zero(rz), .result_ones(ro));
    always @(negedge clk) begin
      bit ev, er;
      int e;
      #2;
      if (rst) begin
        chk($sformatf("u%0d.rst_ov", g), 64'(ov), 64'd0);
        chk($sformatf("u%0d.rst_res", g), 64'(res), 64'd0);
        chk($sformatf("u%0d.rst_flags", g), 64'({rz, ro}), 64'd0);
        chk($sformatf("u%0d.rst_ir", g), 64'(ir), 64'd1);
        acc_now = 0;
        emit_now = 0;
      end else begin
        ev = 0;
        if (q.size() > 0) begin
          e = q[0].acc + S - 1;
          if (last_dep > e) e = last_dep;
          ev = e <= cyc;
        end
        er = out_ready || q.size() < S;
        chk($sformatf("u%0d.in_ready", g), 64'(ir), 64'(er));
        chk($sformatf("u%0d.out_valid", g), 64'(ov), 64'(ev));
        chk($sformatf("u%0d.excl", g), 64'(rz & ro), 64'd0);
        if (ev) begin
          chk($sformatf("u%0d.result", g), 64'(res), q[0].d);
          chk($sformatf("u%0d.zero", g), 64'(rz), 64'(q[0].d == 0));
          chk($sformatf("u%0d.ones", g), 64'(ro), 64'(q[0].d == M));
        end
        acc_now = in_valid && er;
        emit_now = ev && out_ready;
      end
    end
    always @(posedge clk) begin
      cyc++;
      if (rst) q.delete();
      else begin
        if (emit_now) begin
          void'(q.pop_front());
          last_dep = cyc;
        end
        if (acc_now) q.push_back('{ref_op(a, b, op) & M, cyc});
      end
      acc_now = 0;
      emit_now = 0;
    end
    always @(posedge rst) begin
      q.delete();
      acc_now = 0;
      emit_now = 0;
      #1;
      chk($sformatf("u%0d.async_ov", g), 64'(ov), 64'd0);
      chk($sformatf("u%0d.async_ir", g), 64'(ir), 64'd1);
    end
  end
  task automatic drive(logic v, logic [63:0] x, logic [63:0] y, logic [2:0] o, logic r);
    @(negedge clk);
    in_valid = v;
    a = x;
    b = y;
    op = o;
    out_ready = r;
  endtask
  initial begin
    #1 rst = 1;
    repeat (2) drive(0, 0, 0, 0, 1);
    rst = 0;
    drive(1, 64'h0000_FFFF, 0, 3'd0, 1);
    repeat (5) drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) drive(1, 64'hF0F0_1234, 64'h0FF0_FFFF, 3'(i), 1);
    repeat (6) drive(0, 0, 0, 0, 1);
    drive(1, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 3'd3, 1);
    drive(1, 0, 0, 3'd0, 1);
    drive(1, 64'hFFFF_FFFF, 64'h0, 3'd7, 1);
    repeat (6) drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) drive(1, 64'h1111 * (i + 1), 64'h5A5A_A5A5, 3'(i), 0);
    repeat (7) drive(0, 0, 0, 0, 1);
    drive(1, 64'h1234_5678, 64'h0F0F_0F0F, 3'd1, 0);
    repeat (4) drive(0, 0, 0, 0, 0);
    repeat (4) drive(1, 64'hCAFE_F00D, 64'hFFFF_0000, 3'd2, 0);
    repeat (8) drive(0, 0, 0, 0, 1);
    drive(1, 64'hAAAA_5555, 64'h0, 3'd0, 0);
    drive(1, 64'h5555_AAAA, 64'h0, 3'd7, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    #4 rst = 1;
    #2 rst = 0;
    repeat (6) drive(0, 0, 0, 0, 1);
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
            3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 1) != 0, {$urandom, $urandom}, {$urandom, $urandom},
            3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
    repeat (8) drive(0, 0, 0, 0, 1);
    @(negedge clk);
    #5;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_logic_unit.md
Name: pipelined_logic_unit

Overview:
- Parametrised, pipelined bitwise logic unit; successor to the fixed 32-bit inverter.
- Applies one of eight bitwise operations (NOT, AND, OR, XOR, NAND, NOR, XNOR, PASS) to WIDTH-bit operands.
- Carries results through a STAGES-deep register pipeline with valid/ready flow control and per-beat zero/all-ones flags.
- Sits in the ALU datapath beside the adder and shifter and feeds the ALU result mux.

Parameters:
- WIDTH, 32, operand and result width in bits (legal 1..64).
- STAGES, 2, number of register stages from input to output (legal 1..4).

Ports:
- clock, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, the input beat (in_A, in_B, in_op) is valid.
- in_ready, output, 1, the unit accepts the input beat this cycle.
- in_A, input, WIDTH, operand A.
- in_B, input, WIDTH, operand B (ignored for NOT and PASS).
- in_op, input, 3, operation select.
- out_valid, output, 1, the result beat is valid.
- out_ready, input, 1, downstream accepts the result.
- result, output, WIDTH, operation result.
- result_zero, output, 1, result equals all zeros.
- result_ones, output, 1, result equals all ones.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Op encoding:
  - 000 NOT: ~A
  - 001 AND: A&B
  - 010 OR: A|B
  - 011 XOR: A^B
  - 100 NAND: ~(A&B)
  - 101 NOR: ~(A|B)
  - 110 XNOR: ~(A^B)
  - 111 PASS: A
- Compute and flags:
  - The operation is computed combinationally from the inputs.
  - Result and both flags are captured into stage 0 on acceptance.
  - Stages 1..STAGES-1 are pure delay registers (data + flags + valid).
- Stage state: each stage s holds valid[s], data[s], zero[s], ones[s].
- Outputs: out_valid = valid[STAGES-1]; result, result_zero and result_ones come from the last stage. No combinational path from in_A, in_B or in_op to any output.
- Ready chain (combinational):
  - ready[STAGES] = out_ready.
  - ready[s] = !valid[s] | ready[s+1].
  - in_ready = ready[0].
- Transfers:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage update when ready[s] = 1:
  - Stage 0: valid[0] <= in_valid; data and flags load from the compute logic.
  - Stage s>0: takes stage s-1 contents.
  - A stage with ready[s] = 0 holds all contents.
- Bubble collapse: an empty stage accepts from upstream even while downstream stalls. Consequences:
  - Throughput is 1 beat/cycle with out_ready high.
  - With out_ready low, the pipe absorbs up to STAGES beats, then deasserts in_ready.
- Latency: a beat accepted at edge N appears at the outputs after edge N+STAGES-1, i.e. out_valid is visible STAGES cycles after acceptance, with no stall.
- Ordering: strictly in order; no beat is dropped or duplicated.
- Data hold: data registers of invalid stages may update (don't-care). Result is held stable while out_valid & !out_ready.
- Flags:
  - result_zero = (result == 0).
  - result_ones = (result == all ones).
  - Both flags are 1 only when WIDTH=1 is impossible, i.e. never both; verify mutually exclusive.
- Reset:
  - All valid[s] = 0, data = 0, flags = 0; out_valid = 0, result = 0, result_zero = 0, result_ones = 0.
  - in_ready = 1 whenever the pipe is empty, including the first cycle after reset deassertion.
- Reset mid-operation: all in-flight beats are discarded immediately (asynchronous); the pipe restarts empty.
- Simultaneous accept and emit with a full pipe and out_ready = 1: the pipe shifts and in_ready = 1; there is no bubble.
- Illegal parameters: the elaboration-time check fails for STAGES < 1 or WIDTH < 1.

Test Plan:
- Reset and NOT, WIDTH=32, STAGES=2:
  - After reset, out_valid=0, result=0, in_ready=1.
  - Send op=000, A=32'h0000_FFFF → after 2 cycles out_valid=1, result=32'hFFFF_0000, result_zero=0, result_ones=0.
- All ops: A=32'hF0F0_1234, B=32'h0FF0_FFFF, ops 000..111 back-to-back with out_ready=1 → results 0F0F_EDCB, 00F0_1234, FFF0_FFFF, FF00_EDCB, FF0F_EDCB, 000F_0000, 00FF_1234, F0F0_1234, in order on 8 consecutive cycles.
- Flags:
  - op=011, A=B=32'hDEAD_BEEF → result=0, result_zero=1.
  - op=000, A=0 → result=32'hFFFF_FFFF, result_ones=1.
- Backpressure:
  - out_ready=0, in_valid=1 continuously → exactly 2 beats accepted, then in_ready=0; result held stable.
  - Raise out_ready → the beats drain in order; in_ready=1 in that same cycle.
- Bubble collapse: send one beat, then hold out_ready=0 until the beat reaches the last stage; send a second beat → accepted (in_ready=1), then in_ready drops.
- Reset mid-flight: with 2 beats in flight, pulse reset asynchronously between edges → out_valid falls immediately; no stale beat emerges afterwards.
- Parameter sweep: repeat the all-ops test at WIDTH=8 and STAGES=1/4 → latency 1 and 4 respectively; results match a bitwise reference.
